// File: rtl/id_stage.sv
// id_stage: instruction decode and register-read stage.
//
// Accepts raw 32-bit OP (R-type) and OP-IMM (I-type) instructions over a
// valid/ready handshake. It decodes each one into a 4-bit ALU operation code,
// reads its operands from an internal 32 x XLEN register file, and presents a
// registered operand bundle to the ALU. The register-file write port belongs
// to writeback.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     upstream handshake, in_instr = raw instruction word
//   wb_en/wb_addr/wb_data register-file write port (x0 writes ignored)
//   out_valid/out_ready   downstream handshake
//   out_op                ADD=0 SUB=1 MUL=2 AND=3 OR=4 XOR=5 SLT=6 SLTU=7
//                         SLL=8 SRL=9 SRA=10 ILLEGAL=15
//   out_a, out_b, out_rd  operands and destination; out_is_imm marks out_b
//                         as an immediate
//   illegal_cnt           saturating count of accepted illegal instructions
//
// Configuration macro: ID_MUL_EN. When defined, funct7=0000001/funct3=000 on
// OP decodes to MUL. Otherwise that encoding is illegal.

module id_stage #(
   parameter int unsigned XLEN = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic            wb_en,
   input  logic [4:0]      wb_addr,
   input  logic [XLEN-1:0] wb_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [3:0]      out_op,
   output logic [XLEN-1:0] out_a,
   output logic [XLEN-1:0] out_b,
   output logic [4:0]      out_rd,
   output logic            out_is_imm,
   output logic [7:0]      illegal_cnt
);

   localparam logic [3:0] OpAdd  = 4'd0;
   localparam logic [3:0] OpSub  = 4'd1;
   localparam logic [3:0] OpMul  = 4'd2;
   localparam logic [3:0] OpAnd  = 4'd3;
   localparam logic [3:0] OpOr   = 4'd4;
   localparam logic [3:0] OpXor  = 4'd5;
   localparam logic [3:0] OpSlt  = 4'd6;
   localparam logic [3:0] OpSltu = 4'd7;
   localparam logic [3:0] OpSll  = 4'd8;
   localparam logic [3:0] OpSrl  = 4'd9;
   localparam logic [3:0] OpSra  = 4'd10;
   localparam logic [3:0] OpIll  = 4'd15;

   localparam logic [6:0] OpcOp    = 7'b0110011;
   localparam logic [6:0] OpcOpImm = 7'b0010011;

   // Instruction fields
   logic [6:0] opcode;
   logic [4:0] rd;
   logic [2:0] funct3;
   logic [4:0] rs1;
   logic [4:0] rs2;
   logic [6:0] funct7;

   assign opcode = in_instr[6:0];
   assign rd     = in_instr[11:7];
   assign funct3 = in_instr[14:12];
   assign rs1    = in_instr[19:15];
   assign rs2    = in_instr[24:20];
   assign funct7 = in_instr[31:25];

   // State
   logic [XLEN-1:0] rf_q [32];
   logic            out_valid_q, out_valid_d;
   logic [3:0]      out_op_q, out_op_d;
   logic [XLEN-1:0] out_a_q, out_a_d;
   logic [XLEN-1:0] out_b_q, out_b_d;
   logic [4:0]      out_rd_q, out_rd_d;
   logic            out_is_imm_q, out_is_imm_d;
   logic [7:0]      illegal_cnt_q, illegal_cnt_d;

   logic xfer;
   assign in_ready = !out_valid_q || out_ready;
   assign xfer     = in_valid && in_ready;

   // Register read with write-through bypass. x0 is hard-wired to zero, so a
   // writeback aimed at x0 never bypasses.
   logic [XLEN-1:0] rs1_val, rs2_val;

   always_comb begin
      rs1_val = rf_q[rs1];
      if (rs1 == 5'd0) begin
         rs1_val = '0;
      end else if (wb_en && (wb_addr == rs1)) begin
         rs1_val = wb_data;
      end
   end

   always_comb begin
      rs2_val = rf_q[rs2];
      if (rs2 == 5'd0) begin
         rs2_val = '0;
      end else if (wb_en && (wb_addr == rs2)) begin
         rs2_val = wb_data;
      end
   end

   // Immediate forms
   logic [XLEN-1:0] imm_sext;
   logic [XLEN-1:0] shamt_zext;

   assign imm_sext   = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
   assign shamt_zext = {{(XLEN-5){1'b0}}, in_instr[24:20]};

   // Decode
   logic [3:0]      dec_op;
   logic [XLEN-1:0] dec_b;
   logic            dec_is_imm;

   always_comb begin
      dec_op     = OpIll;
      dec_b      = rs2_val;
      dec_is_imm = 1'b0;
      case (opcode)
         OpcOp: begin
            case ({funct7, funct3})
               {7'b0000000, 3'b000}: dec_op = OpAdd;
               {7'b0100000, 3'b000}: dec_op = OpSub;
`ifdef ID_MUL_EN
               {7'b0000001, 3'b000}: dec_op = OpMul;
`endif
               {7'b0000000, 3'b111}: dec_op = OpAnd;
               {7'b0000000, 3'b110}: dec_op = OpOr;
               {7'b0000000, 3'b100}: dec_op = OpXor;
               {7'b0000000, 3'b010}: dec_op = OpSlt;
               {7'b0000000, 3'b011}: dec_op = OpSltu;
               {7'b0000000, 3'b001}: dec_op = OpSll;
               {7'b0000000, 3'b101}: dec_op = OpSrl;
               {7'b0100000, 3'b101}: dec_op = OpSra;
               default:              dec_op = OpIll;
            endcase
         end
         OpcOpImm: begin
            dec_is_imm = 1'b1;
            dec_b      = imm_sext;
            case (funct3)
               3'b000: dec_op = OpAdd;
               3'b111: dec_op = OpAnd;
               3'b110: dec_op = OpOr;
               3'b100: dec_op = OpXor;
               3'b010: dec_op = OpSlt;
               3'b011: dec_op = OpSltu;
               3'b001: begin
                  dec_b  = shamt_zext;
                  dec_op = (funct7 == 7'b0000000) ? OpSll : OpIll;
               end
               3'b101: begin
                  dec_b = shamt_zext;
                  if (funct7 == 7'b0000000) begin
                     dec_op = OpSrl;
                  end else if (funct7 == 7'b0100000) begin
                     dec_op = OpSra;
                  end else begin
                     dec_op = OpIll;
                  end
               end
               default: dec_op = OpIll;
            endcase
         end
         default: dec_op = OpIll;
      endcase
   end

   // Output bundle and illegal counter next state
   always_comb begin
      out_valid_d   = out_valid_q;
      out_op_d      = out_op_q;
      out_a_d       = out_a_q;
      out_b_d       = out_b_q;
      out_rd_d      = out_rd_q;
      out_is_imm_d  = out_is_imm_q;
      illegal_cnt_d = illegal_cnt_q;
      if (xfer) begin
         out_valid_d = 1'b1;
         if (dec_op == OpIll) begin
            // Illegal bundles carry no operands so the ALU sees a clean NOP.
            out_op_d     = OpIll;
            out_a_d      = '0;
            out_b_d      = '0;
            out_rd_d     = '0;
            out_is_imm_d = 1'b0;
            if (illegal_cnt_q != 8'hFF) begin
               illegal_cnt_d = illegal_cnt_q + 8'd1;
            end
         end else begin
            out_op_d     = dec_op;
            out_a_d      = rs1_val;
            out_b_d      = dec_b;
            out_rd_d     = rd;
            out_is_imm_d = dec_is_imm;
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q   <= 1'b0;
         out_op_q      <= '0;
         out_a_q       <= '0;
         out_b_q       <= '0;
         out_rd_q      <= '0;
         out_is_imm_q  <= 1'b0;
         illegal_cnt_q <= '0;
      end else begin
         out_valid_q   <= out_valid_d;
         out_op_q      <= out_op_d;
         out_a_q       <= out_a_d;
         out_b_q       <= out_b_d;
         out_rd_q      <= out_rd_d;
         out_is_imm_q  <= out_is_imm_d;
         illegal_cnt_q <= illegal_cnt_d;
      end
   end

   // Register file
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) begin
            rf_q[i] <= '0;
         end
      end else if (wb_en && (wb_addr != 5'd0)) begin
         rf_q[wb_addr] <= wb_data;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_op      = out_op_q;
   assign out_a       = out_a_q;
   assign out_b       = out_b_q;
   assign out_rd      = out_rd_q;
   assign out_is_imm  = out_is_imm_q;
   assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_id_stage.sv
// Testbench for id_stage. A reference decoder plus a shadow register file
// predicts each bundle at acceptance and queues it. A monitor pops the queue
// and compares whenever the ALU consumes a bundle. The scenario tasks also
// make their own direct checks.

module tb_id_stage;

   localparam int unsigned XLEN = 16;

   typedef struct packed {
      logic [3:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [4:0]  rd;
      logic        imm;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [15:0] wb_data;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_op;
   logic [15:0] out_a;
   logic [15:0] out_b;
   logic [4:0]  out_rd;
   logic        out_is_imm;
   logic [7:0]  illegal_cnt;

   int vectors = 0;
   int miscompares = 0;

   exp_t        sb_q[$];
   logic [15:0] rf_m [32];
   int          cnt_m = 0;

   id_stage #(.XLEN(XLEN)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_instr   (in_instr),
      .wb_en      (wb_en),
      .wb_addr    (wb_addr),
      .wb_data    (wb_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_op     (out_op),
      .out_a      (out_a),
      .out_b      (out_b),
      .out_rd     (out_rd),
      .out_is_imm (out_is_imm),
      .illegal_cnt(illegal_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] rd_m(input logic [4:0] idx);
      if (idx == 5'd0) return 16'h0;
      if (wb_en && wb_addr == idx) return wb_data;
      return rf_m[idx];
   endfunction

   function automatic exp_t model(input logic [31:0] ins);
      exp_t       e;
      logic [6:0] f7;
      logic [2:0] f3;
      logic [3:0] op;
      f7 = ins[31:25];
      f3 = ins[14:12];
      op = 4'd15;
      e  = '0;
      if (ins[6:0] == 7'b0110011) begin
         e.b   = rd_m(ins[24:20]);
         e.imm = 1'b0;
         if (f7 == 7'b0000000) begin
            case (f3)
               3'd0: op = 4'd0;
               3'd7: op = 4'd3;
               3'd6: op = 4'd4;
               3'd4: op = 4'd5;
               3'd2: op = 4'd6;
               3'd3: op = 4'd7;
               3'd1: op = 4'd8;
               3'd5: op = 4'd9;
               default: op = 4'd15;
            endcase
         end else if (f7 == 7'b0100000 && f3 == 3'd0) begin
            op = 4'd1;
         end else if (f7 == 7'b0100000 && f3 == 3'd5) begin
            op = 4'd10;
`ifdef ID_MUL_EN
         end else if (f7 == 7'b0000001 && f3 == 3'd0) begin
            op = 4'd2;
`endif
         end
      end else if (ins[6:0] == 7'b0010011) begin
         e.imm = 1'b1;
         e.b   = {{4{ins[31]}}, ins[31:20]};
         case (f3)
            3'd0: op = 4'd0;
            3'd7: op = 4'd3;
            3'd6: op = 4'd4;
            3'd4: op = 4'd5;
            3'd2: op = 4'd6;
            3'd3: op = 4'd7;
            3'd1: op = (f7 == 7'b0000000) ? 4'd8 : 4'd15;
            3'd5: op = (f7 == 7'b0000000) ? 4'd9 :
                       (f7 == 7'b0100000) ? 4'd10 : 4'd15;
            default: op = 4'd15;
         endcase
         if (f3 == 3'd1 || f3 == 3'd5) e.b = {11'd0, ins[24:20]};
      end
      if (op == 4'd15) begin
         e    = '0;
         e.op = 4'd15;
      end else begin
         e.op = op;
         e.a  = rd_m(ins[19:15]);
         e.rd = ins[11:7];
      end
      return e;
   endfunction

   function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3,
                                       input logic [4:0] rd, input logic [6:0] opc);
      return {f7, rs2, rs1, f3, rd, opc};
   endfunction

   // Scoreboard monitor: pop on consumption, predict on acceptance, then
   // shadow the writeback.
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid && out_ready) begin
            vectors++;
            if (sb_q.size() == 0) begin
               miscompares++;
               $display("FAIL sb_underflow: bundle op=%0d with nothing expected", out_op);
            end else begin
               if ({out_op, out_a, out_b, out_rd, out_is_imm} !== sb_q[0]) begin
                  miscompares++;
                  $display("FAIL sb_bundle: got op=%0d a=%h b=%h rd=%0d imm=%b, exp op=%0d a=%h b=%h rd=%0d imm=%b",
                           out_op, out_a, out_b, out_rd, out_is_imm, sb_q[0].op, sb_q[0].a,
                           sb_q[0].b, sb_q[0].rd, sb_q[0].imm);
               end
               void'(sb_q.pop_front());
            end
         end
         if (in_valid && in_ready) begin
            sb_q.push_back(model(in_instr));
            if (sb_q[$].op == 4'd15 && cnt_m != 255) cnt_m <= cnt_m + 1;
         end
         if (wb_en && wb_addr != 5'd0) rf_m[wb_addr] <= wb_data;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] ins);
      in_instr = ins;
      in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
   endtask

   task automatic write_reg(input logic [4:0] a, input logic [15:0] d);
      wb_en   = 1'b1;
      wb_addr = a;
      wb_data = d;
      cyc();
      wb_en   = 1'b0;
   endtask

   task automatic flush_model();
      sb_q.delete();
      for (int i = 0; i < 32; i++) rf_m[i] = 16'h0;
      cnt_m = 0;
   endtask

   task automatic test_reset();
      vectors++;
      if ({out_valid, out_op, out_a, out_b, out_rd, out_is_imm, illegal_cnt} !== '0) begin
         miscompares++;
         $display("FAIL reset_state: got v=%b op=%0d a=%h b=%h rd=%0d imm=%b cnt=%0d, exp all 0",
                  out_valid, out_op, out_a, out_b, out_rd, out_is_imm, illegal_cnt);
      end
      cyc();
      rst_n = 1'b1;
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_ready: got %b exp 1", in_ready);
      end
   endtask

   task automatic test_add();
      out_ready = 1'b1;
      write_reg(5'd5, 16'h0007);
      write_reg(5'd6, 16'h0003);
      send(32'h006280B3);
      vectors++;
      if ({out_valid, out_op, out_a, out_b, out_rd, out_is_imm} !==
          {1'b1, 4'd0, 16'h0007, 16'h0003, 5'd1, 1'b0}) begin
         miscompares++;
         $display("FAIL add: got v=%b op=%0d a=%h b=%h rd=%0d imm=%b, exp 1/0/0007/0003/1/0",
                  out_valid, out_op, out_a, out_b, out_rd, out_is_imm);
      end
   endtask

   task automatic test_imm();
      send(32'hFFF28113);
      vectors++;
      if ({out_op, out_a, out_b, out_rd, out_is_imm} !== {4'd0, 16'h0007, 16'hFFFF, 5'd2, 1'b1}) begin
         miscompares++;
         $display("FAIL addi: got op=%0d a=%h b=%h rd=%0d imm=%b, exp 0/0007/ffff/2/1",
                  out_op, out_a, out_b, out_rd, out_is_imm);
      end
      send(32'h4042D193);
      vectors++;
      if ({out_op, out_b, out_rd, out_is_imm} !== {4'd10, 16'h0004, 5'd3, 1'b1}) begin
         miscompares++;
         $display("FAIL srai: got op=%0d b=%h rd=%0d imm=%b, exp 10/0004/3/1",
                  out_op, out_b, out_rd, out_is_imm);
      end
   endtask

   task automatic test_backpressure();
      logic [41:0] snap;
      out_ready = 1'b0;
      send(enc(7'b0000000, 5'd6, 5'd5, 3'd4, 5'd9, 7'b0110011));  // XOR x9,x5,x6
      snap = {out_op, out_a, out_b, out_rd, out_is_imm};
      in_instr = enc(7'b0000000, 5'd5, 5'd6, 3'd7, 5'd10, 7'b0110011);  // AND x10,x6,x5
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vectors++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
             {out_op, out_a, out_b, out_rd, out_is_imm} !== snap) begin
            miscompares++;
            $display("FAIL bp_hold[%0d]: got rdy=%b v=%b bundle=%h, exp 0/1/%h",
                     i, in_ready, out_valid, {out_op, out_a, out_b, out_rd, out_is_imm}, snap);
         end
      end
      cyc();
      out_ready = 1'b1;
      cyc();
      in_valid = 1'b0;
      vectors++;
      if (out_valid !== 1'b1 || out_op !== 4'd3 || out_rd !== 5'd10) begin
         miscompares++;
         $display("FAIL bp_release: got v=%b op=%0d rd=%0d, exp 1/3/10", out_valid, out_op, out_rd);
      end
      cyc();
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL bp_drain: got v=%b exp 0", out_valid);
      end
   endtask

   task automatic test_bypass();
      wb_en   = 1'b1;
      wb_addr = 5'd5;
      wb_data = 16'h1234;
      send(32'h400280B3);  // SUB x1,x5,x0
      wb_en = 1'b0;
      vectors++;
      if ({out_op, out_a, out_b} !== {4'd1, 16'h1234, 16'h0000}) begin
         miscompares++;
         $display("FAIL bypass: got op=%0d a=%h b=%h, exp 1/1234/0000", out_op, out_a, out_b);
      end
      write_reg(5'd0, 16'hBEEF);
      wb_en   = 1'b1;
      wb_addr = 5'd0;
      wb_data = 16'hA5A5;
      send(32'h000000B3);  // ADD x1,x0,x0
      wb_en = 1'b0;
      vectors++;
      if ({out_a, out_b} !== 32'h0) begin
         miscompares++;
         $display("FAIL x0_read: got a=%h b=%h, exp 0000/0000", out_a, out_b);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] prog [10];
      write_reg(5'd7, 16'h8001);
      prog[0] = enc(7'b0000000, 5'd6, 5'd7, 3'd6, 5'd11, 7'b0110011);  // OR
      prog[1] = enc(7'b0000000, 5'd6, 5'd7, 3'd2, 5'd12, 7'b0110011);  // SLT
      prog[2] = enc(7'b0000000, 5'd6, 5'd7, 3'd3, 5'd13, 7'b0110011);  // SLTU
      prog[3] = enc(7'b0000000, 5'd6, 5'd7, 3'd1, 5'd14, 7'b0110011);  // SLL
      prog[4] = enc(7'b0000000, 5'd6, 5'd7, 3'd5, 5'd15, 7'b0110011);  // SRL
      prog[5] = enc(7'b0100000, 5'd6, 5'd7, 3'd5, 5'd16, 7'b0110011);  // SRA
      prog[6] = enc(7'b1000000, 5'd31, 5'd7, 3'd7, 5'd17, 7'b0010011); // ANDI -2017
      prog[7] = enc(7'b0111111, 5'd31, 5'd7, 3'd3, 5'd18, 7'b0010011); // SLTIU 2047
      prog[8] = enc(7'b0000000, 5'd15, 5'd7, 3'd1, 5'd19, 7'b0010011); // SLLI 15
      prog[9] = enc(7'b0100000, 5'd6, 5'd7, 3'd1, 5'd20, 7'b0010011);  // bad SLLI funct7
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_instr = prog[i];
         cyc();
         vectors++;
         if (out_valid !== 1'b1 || out_rd !== ((i == 9) ? 5'd0 : 5'(11 + i))) begin
            miscompares++;
            $display("FAIL b2b[%0d]: got v=%b rd=%0d", i, out_valid, out_rd);
         end
      end
      in_valid = 1'b0;
      cyc();
   endtask

   task automatic test_mul();
      logic [7:0] base;
      base = illegal_cnt;
      send(32'h026280B3);
      vectors++;
`ifdef ID_MUL_EN
      if ({out_op, out_a, out_b, out_rd} !== {4'd2, 16'h1234, 16'h0003, 5'd1} ||
          illegal_cnt !== base) begin
         miscompares++;
         $display("FAIL mul: got op=%0d a=%h b=%h rd=%0d cnt=%0d, exp 2/1234/0003/1 cnt=%0d",
                  out_op, out_a, out_b, out_rd, illegal_cnt, base);
      end
`else
      if ({out_op, out_a, out_b, out_rd} !== {4'd15, 16'h0, 16'h0, 5'd0} ||
          illegal_cnt !== base + 8'd1) begin
         miscompares++;
         $display("FAIL mul: got op=%0d a=%h b=%h rd=%0d cnt=%0d, exp 15/0/0/0 cnt=%0d",
                  out_op, out_a, out_b, out_rd, illegal_cnt, base + 8'd1);
      end
`endif
   endtask

   task automatic test_illegal();
      logic [7:0] base;
      base     = illegal_cnt;
      in_instr = 32'h0;
      in_valid = 1'b1;
      for (int i = 1; i <= 300; i++) begin
         cyc();
         if (i == 10) begin
            vectors++;
            if (illegal_cnt !== base + 8'd10) begin
               miscompares++;
               $display("FAIL ill_count10: got %0d exp %0d", illegal_cnt, base + 8'd10);
            end
         end
      end
      in_valid = 1'b0;
      vectors++;
      if (illegal_cnt !== 8'd255 || out_op !== 4'd15 || illegal_cnt !== 8'(cnt_m)) begin
         miscompares++;
         $display("FAIL ill_saturate: got cnt=%0d op=%0d, exp 255/15 (model %0d)",
                  illegal_cnt, out_op, cnt_m);
      end
      cyc();
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      send(32'h006280B3);
      vectors++;
      if (out_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_pre: got v=%b exp 1", out_valid);
      end
      #2;
      rst_n = 1'b0;
      #1;
      vectors++;
      if (out_valid !== 1'b0 || illegal_cnt !== 8'd0 || out_op !== 4'd0 || out_a !== 16'h0) begin
         miscompares++;
         $display("FAIL rst_async: got v=%b cnt=%0d op=%0d a=%h, exp 0/0/0/0",
                  out_valid, illegal_cnt, out_op, out_a);
      end
      flush_model();
      cyc();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      send(enc(7'b0000000, 5'd7, 5'd5, 3'd0, 5'd1, 7'b0110011));  // ADD x1,x5,x7
      vectors++;
      if ({out_valid, out_a, out_b} !== {1'b1, 16'h0, 16'h0}) begin
         miscompares++;
         $display("FAIL rst_rf_clear: got v=%b a=%h b=%h, exp 1/0000/0000", out_valid, out_a, out_b);
      end
      cyc();
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_instr  = 32'h0;
      wb_en     = 1'b0;
      wb_addr   = 5'd0;
      wb_data   = 16'h0;
      out_ready = 1'b1;
      flush_model();
      cyc();
      test_reset();
      test_add();
      test_imm();
      test_backpressure();
      test_bypass();
      test_back_to_back();
      test_mul();
      test_illegal();
      test_reset_mid();
      cyc();
      vectors++;
      if (sb_q.size() != 0) begin
         miscompares++;
         $display("FAIL sb_leftover: got %0d pending, exp 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction decode and register-read stage for the 16-bit-datapath RISC-V core. It accepts raw 32-bit R-type and I-type (OP / OP-IMM) instructions over a valid/ready handshake and decodes them into a compact ALU operation code. It reads operands from an internal 32-entry register file and presents a registered operand bundle to the downstream ALU. It also owns the register-file write port driven by writeback.

## Interface
- XLEN, 16, register and operand width; immediates are sign-extended or truncated to XLEN.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  an instruction is offered on in_instr.
- in_ready  out  1  the stage accepts in_instr this cycle.
- in_instr  in  32  raw instruction word.
- wb_en  in  1  register-file write enable.
- wb_addr  in  5  destination register for the write.
- wb_data  in  XLEN  write data.
- out_valid  out  1  the decoded bundle is valid.
- out_ready  in  1  the ALU consumes the bundle this cycle.
- out_op  out  4  operation code: ADD=0, SUB=1, MUL=2, AND=3, OR=4, XOR=5, SLT=6, SLTU=7, SLL=8, SRL=9, SRA=10, ILLEGAL=15.
- out_a  out  XLEN  rs1 value.
- out_b  out  XLEN  rs2 value, or the processed immediate.
- out_rd  out  5  destination register.
- out_is_imm  out  1  out_b came from the immediate.
- illegal_cnt  out  8  saturating count of accepted illegal instructions.

## Operation
- Handshake:
  - in_ready = !out_valid || out_ready, which is combinational.
  - A transfer occurs when in_valid && in_ready; the output register loads in that cycle.
  - out_valid is set on a transfer. It is cleared on out_ready when no new transfer occurs in the same cycle.
  - While out_valid && !out_ready, the out_* fields hold stable.
- Decode, for opcode 0110011 (R-type):
  - funct3/funct7 pairs map as follows: 000/0000000 ADD, 000/0100000 SUB, 000/0000001 MUL, 111/0 AND, 110/0 OR, 100/0 XOR, 010/0 SLT, 011/0 SLTU, 001/0 SLL, 101/0 SRL, 101/0100000 SRA.
  - out_b = rs2 value; out_is_imm = 0.
- Decode, for opcode 0010011 (I-type):
  - funct3 maps as: 000 ADD, 111 AND, 110 OR, 100 XOR, 010 SLT, 011 SLTU.
  - For these, out_b = sign-extended imm[11:0] truncated to XLEN.
  - Shifts map as: 001 with funct7=0 is SLL; 101 with funct7=0 is SRL; 101 with funct7=0100000 is SRA.
  - For shifts, out_b = zero-extended shamt instr[24:20].
  - out_is_imm = 1 for all I-type forms.
- Illegal instructions: any other opcode, or any other funct combination.
  - out_op = 15, out_rd = 0, out_a = 0, out_b = 0, out_is_imm = 0.
  - illegal_cnt increments on acceptance and saturates at 255.
- Register file: 32 x XLEN.
  - x0 reads as 0 always; writes to x0 are ignored.
  - Writes take effect at the clock edge when wb_en = 1.
- Write-through bypass: if wb_en and wb_addr equals a nonzero source index in the transfer cycle, that operand takes wb_data.
- Operands are sampled only at acceptance. A later writeback does not update a held bundle; downstream forwarding covers that case.

## Timing
- Latency is 1 cycle from acceptance to out_valid.
- Throughput is 1 instruction per cycle when out_ready stays high.
- Reset values:
  - out_valid = 0, out_op = 0, out_a = 0, out_b = 0, out_rd = 0, out_is_imm = 0, illegal_cnt = 0.
  - All register-file entries = 0.
- Reset asserted mid-operation discards any held bundle immediately and asynchronously. Any write in that cycle is lost.
- A writeback to a register in the same cycle as a read of that register returns wb_data, via the bypass.
- Backpressure: out_valid && !out_ready forces in_ready = 0. Writebacks still proceed.
- out_valid && out_ready together with in_valid gives back-to-back replacement with no bubble.

## Configuration
- ID_MUL_EN:
  - Defined: funct7 = 0000001 with funct3 = 000 decodes to MUL (2).
  - Undefined: that encoding is illegal (out_op = 15, counted in illegal_cnt). No MUL code is ever emitted.

## Test plan
- Reset, then write x5 = 0x0007 and x6 = 0x0003; offer ADD x1,x5,x6 (0x006280B3) -> next cycle out_valid = 1, out_op = 0, out_a = 7, out_b = 3, out_rd = 1.
- ADDI x2,x5,-1 (0xFFF28113) -> out_op = 0, out_b = 0xFFFF, out_is_imm = 1; SRAI x3,x5,4 (0x4042D193) -> out_op = 10, out_b = 4.
- Hold out_ready = 0 for 3 cycles with in_valid = 1 -> in_ready = 0 and out_* stable throughout; release -> next instruction loads the following cycle with no loss.
- Same-cycle wb_en = 1, wb_addr = 5, wb_data = 0x1234 while SUB x1,x5,x0 is accepted -> out_a = 0x1234, out_b = 0; a write to x0 leaves x0 reading 0.
- Offer 0x00000000 repeatedly 300 times -> out_op = 15 each time, illegal_cnt saturates at 255; MUL x1,x5,x6 (0x026280B3) gives out_op = 2 with ID_MUL_EN, and 15 with the counter incrementing without it.
- Assert rst_n low while out_valid = 1 -> out_valid drops immediately, illegal_cnt = 0, and all registers read 0 after release.
